// File: rtl/pipe_ctrl_pkg.sv
// Shared field widths and instruction layout for the issue controller and pipeline datapath.
package pipe_ctrl_pkg;

    localparam int REG_W   = 4;
    localparam int FUNC_W  = 4;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 3 * REG_W + FUNC_W + ADDR_W;

    // fifo_cnt is a fixed 3-bit port, so queue depth is limited to 7 entries
    localparam int CNT_W   = 3;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
    } sb_slot_t;

    // True when the instruction reads the given register through either source
    function automatic logic reads_reg(input instr_t instr, input logic [REG_W-1:0] r);
        return (instr.rs1 == r) || (instr.rs2 == r);
    endfunction

endpackage

// File: rtl/pipe_instr_fifo.sv
// In-order instruction queue with occupancy count; head entry is visible combinationally.
module pipe_instr_fifo
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSTR_W
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap at DEPTH-1 so non-power-of-two depths stay in range
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only slots between the pointers are ever read meaningfully
    always_ff @(posedge clk1) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: queues instructions, blocks RAW hazards against recent issues, issues in order.
module pipe_issue_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HAZ_WIN = 2
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [FUNC_W-1:0] in_func,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              iss_valid,
    output logic [REG_W-1:0]  iss_rs1,
    output logic [REG_W-1:0]  iss_rs2,
    output logic [REG_W-1:0]  iss_rd,
    output logic [FUNC_W-1:0] iss_func,
    output logic [ADDR_W-1:0] iss_addr,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic [7:0]        stall_cnt,
    output logic              busy
);

    instr_t   in_instr;
    instr_t   head;
    logic     q_full;
    logic     q_empty;
    logic     hazard;
    logic     issue;
    logic     sb_any;
    sb_slot_t sb [HAZ_WIN];

    assign in_instr = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};

    // The queue refuses pushes when full even if the head pops on the same edge
    pipe_instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .push  (in_valid),
        .pop   (issue),
        .wdata (in_instr),
        .rdata (head),
        .count (fifo_cnt),
        .full  (q_full),
        .empty (q_empty)
    );

    assign in_ready = !q_full;
    assign issue    = !q_empty && !hazard;
    assign busy     = !q_empty || sb_any;

    // Head is blocked while any in-flight destination matches one of its sources
    always_comb begin
        hazard = 1'b0;
        sb_any = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (sb[i].valid) begin
                sb_any = 1'b1;
                if (reads_reg(head, sb[i].rd)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Scoreboard ages every edge; a bubble enters whenever nothing issues
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HAZ_WIN; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= '{valid: issue, rd: (issue ? head.rd : '0)};
            for (int i = 1; i < HAZ_WIN; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // Issue register pulses valid for one cycle and holds the last issued fields otherwise
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_func  <= '0;
            iss_addr  <= '0;
        end else begin
            iss_valid <= issue;
            if (issue) begin
                iss_rs1  <= head.rs1;
                iss_rs2  <= head.rs2;
                iss_rd   <= head.rd;
                iss_func <= head.func;
                iss_addr <= head.addr;
            end
        end
    end

    // Stall cycles accumulate while a queued head waits on a hazard, saturating at 255
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!q_empty && hazard && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
